gecko_run_controller: RTL

GECKO_RUN_CONTROLLER -- requirements
Module: gecko_run_controller

---
 rtl/gecko_run_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/gecko_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : gecko_run_controller
// Purpose  : Loads a program image into core memory, holds the core in reset
//            for a fixed number of cycles, releases it, and records how the
//            run ended (finished, faulted or watchdog timeout).
// Revision : 1.0 - initial release
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin load-and-run (honoured in IDLE/DONE only)
//   load_valid/ready          program word handshake
//   load_addr/data/last       program word, its address, end-of-image marker
//   mem_wr_en/addr/data       registered program memory write port
//   core_rst                  active-high reset to the core
//   faulted_flag/finished_flag core status, looked at only while running
//   busy, done, pass, fail, timeout, cycle_count   run status
//
// Configuration
//   GECKO_RUN_CONTROLLER_WATCHDOG_EN : when defined, a run that reaches
//   TIMEOUT_CYCLES without a core flag ends with timeout=1, fail=1.
// ============================================================================
module gecko_run_controller #(
  parameter int unsigned ADDR_SPACE_WIDTH  = 12,
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter logic [31:0] TIMEOUT_CYCLES    = 32'd100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ADDR_SPACE_WIDTH-1:0] load_addr,
  input  logic [31:0]                 load_data,
  input  logic                        load_last,
  output logic                        mem_wr_en,
  output logic [ADDR_SPACE_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]                 mem_wr_data,
  output logic                        core_rst,
  input  logic                        faulted_flag,
  input  logic                        finished_flag,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic [31:0]                 cycle_count
);

  // Reject configurations outside the supported ranges at elaboration.
  if (RESET_HOLD_CYCLES < 1 || RESET_HOLD_CYCLES > 255 || TIMEOUT_CYCLES == 32'd0) begin : g_param_check
    $error("gecko_run_controller: parameter out of range");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Counter is loaded with N-1 on HOLD entry and leaves at zero, giving
  // exactly N cycles in HOLD.
  localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [7:0]  hold_cnt;
  logic [31:0] cnt_inc;
  logic        accept;
  logic        launch;
  logic        flag_any;

  assign accept   = load_valid && load_ready;
  assign launch   = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign flag_any = faulted_flag || finished_flag;
  // Saturating RUN cycle counter value for this cycle.
  assign cnt_inc  = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

`ifdef GECKO_RUN_CONTROLLER_WATCHDOG_EN
  logic wd_expire;
  logic timeout_q;

  // Expiry is judged on the count this cycle will produce, so the run ends
  // with cycle_count equal to TIMEOUT_CYCLES. A core flag always wins.
  assign wd_expire = !flag_any && (cnt_inc == TIMEOUT_CYCLES);
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: if (accept && load_last) state_next = S_HOLD;
      S_HOLD: if (hold_cnt == 8'd0) state_next = S_RUN;
      S_RUN: begin
        if (flag_any) begin
          state_next = S_DONE;
        end
`ifdef GECKO_RUN_CONTROLLER_WATCHDOG_EN
        else if (wd_expire) begin
          state_next = S_DONE;
        end
`endif
      end
      S_DONE: if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    core_rst   = 1'b1;
    busy       = 1'b0;
    load_ready = 1'b0;
    done       = 1'b0;
    case (state)
      // Ready is masked during reset so a beat offered in that cycle is
      // never handshaken.
      S_LOAD: begin
        busy       = 1'b1;
        load_ready = !rst;
      end
      S_HOLD: busy = 1'b1;
      S_RUN: begin
        busy     = 1'b1;
        core_rst = 1'b0;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory write port, hold counter and run status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      hold_cnt    <= 8'd0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      cycle_count <= 32'd0;
`ifdef GECKO_RUN_CONTROLLER_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      mem_wr_en <= accept;
      if (accept) begin
        mem_wr_addr <= load_addr;
        mem_wr_data <= load_data;
      end

      if (state == S_LOAD && accept && load_last) begin
        hold_cnt <= HOLD_INIT;
      end else if (state == S_HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end

      if (launch) begin
        pass        <= 1'b0;
        fail        <= 1'b0;
        cycle_count <= 32'd0;
`ifdef GECKO_RUN_CONTROLLER_WATCHDOG_EN
        timeout_q   <= 1'b0;
`endif
      end

      // The exiting RUN cycle is counted too.
      if (state == S_RUN) begin
        cycle_count <= cnt_inc;
        if (faulted_flag) begin
          fail <= 1'b1;
        end else if (finished_flag) begin
          pass <= 1'b1;
        end
`ifdef GECKO_RUN_CONTROLLER_WATCHDOG_EN
        else if (wd_expire) begin
          fail      <= 1'b1;
          timeout_q <= 1'b1;
        end
`endif
      end
    end
  end

endmodule
`default_nettype wire
